// File: rtl/axi4_lite_rr_master_if.sv
// axi4_lite_rr_master_if: two requester command/response ports plus one AXI4-Lite master bus.
interface axi4_lite_rr_master_if #(
  parameter int ADDRESS_SIZE = 4,
  parameter int DATA_SIZE = 32
);
  logic r0_valid, r0_ready, r0_write, r0_rsp_valid;
  logic [ADDRESS_SIZE-1:0] r0_addr;
  logic [DATA_SIZE-1:0] r0_wdata, r0_rsp_rdata;
  logic [DATA_SIZE/8-1:0] r0_wstrb;
  logic [1:0] r0_rsp_resp;
  logic r1_valid, r1_ready, r1_write, r1_rsp_valid;
  logic [ADDRESS_SIZE-1:0] r1_addr;
  logic [DATA_SIZE-1:0] r1_wdata, r1_rsp_rdata;
  logic [DATA_SIZE/8-1:0] r1_wstrb;
  logic [1:0] r1_rsp_resp;
  logic [ADDRESS_SIZE-1:0] m_axi_awaddr, m_axi_araddr;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DATA_SIZE-1:0] m_axi_wdata, m_axi_rdata;
  logic [DATA_SIZE/8-1:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  modport master (
    input r0_valid, r0_write, r0_addr, r0_wdata, r0_wstrb,
    input r1_valid, r1_write, r1_addr, r1_wdata, r1_wstrb,
    output r0_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_resp,
    output r1_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_resp,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready,
    input m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
  modport slave (
    output r0_valid, r0_write, r0_addr, r0_wdata, r0_wstrb,
    output r1_valid, r1_write, r1_addr, r1_wdata, r1_wstrb,
    input r0_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_resp,
    input r1_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_resp,
    input m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input m_axi_araddr, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/axi4_lite_rr_master.sv
// axi4_lite_rr_master: round-robin arbiter sharing one AXI4-Lite slave between two requesters, one transaction outstanding.
module axi4_lite_rr_master #(
  parameter int ADDRESS_SIZE = 4,
  parameter int DATA_SIZE = 32
) (
  input logic aclk,
  input logic aresetn,
  axi4_lite_rr_master_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, WADDR = 3'd1, RADDR = 3'd2, WRESP = 3'd3, RRESP = 3'd4;
  logic [2:0] state_q, state_d;
  logic last_q, last_d, grant_q, grant_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_SIZE/8-1:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d, rsp_valid_q, rsp_valid_d;
  logic idle, g1;
  assign idle = state_q == IDLE;
  // r1 wins when alone, or on a tie when r0 was served last
  assign g1 = bus.r1_valid & (~bus.r0_valid | ~last_q);
  assign bus.r0_ready = aresetn & idle & bus.r0_valid & ~g1;
  assign bus.r1_ready = aresetn & idle & g1;
  assign bus.m_axi_awaddr = addr_q;
  assign bus.m_axi_araddr = addr_q;
  assign bus.m_axi_wdata = wdata_q;
  assign bus.m_axi_wstrb = wstrb_q;
  assign bus.m_axi_awvalid = state_q == WADDR & ~aw_done_q;
  assign bus.m_axi_wvalid = state_q == WADDR & ~w_done_q;
  assign bus.m_axi_bready = state_q == WRESP;
  assign bus.m_axi_arvalid = state_q == RADDR;
  assign bus.m_axi_rready = state_q == RRESP;
  assign bus.r0_rsp_valid = rsp_valid_q[0];
  assign bus.r1_rsp_valid = rsp_valid_q[1];
  assign bus.r0_rsp_rdata = rdata_q;
  assign bus.r1_rsp_rdata = rdata_q;
  assign bus.r0_rsp_resp = resp_q;
  assign bus.r1_rsp_resp = resp_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    grant_d = grant_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    rsp_valid_d = 2'b00;
    if (idle && (bus.r0_valid || bus.r1_valid)) begin
      grant_d = g1;
      last_d = g1;
      addr_d = g1 ? bus.r1_addr : bus.r0_addr;
      wdata_d = g1 ? bus.r1_wdata : bus.r0_wdata;
      wstrb_d = g1 ? bus.r1_wstrb : bus.r0_wstrb;
      aw_done_d = 1'b0;
      w_done_d = 1'b0;
      state_d = (g1 ? bus.r1_write : bus.r0_write) ? WADDR : RADDR;
    end
    if (state_q == WADDR) begin
      aw_done_d = aw_done_q | (bus.m_axi_awvalid & bus.m_axi_awready);
      w_done_d = w_done_q | (bus.m_axi_wvalid & bus.m_axi_wready);
      state_d = aw_done_d && w_done_d ? WRESP : WADDR;
    end
    if (state_q == RADDR && bus.m_axi_arready) state_d = RRESP;
    if ((state_q == WRESP && bus.m_axi_bvalid) || (state_q == RRESP && bus.m_axi_rvalid)) begin
      rdata_d = state_q == WRESP ? '0 : bus.m_axi_rdata;
      resp_d = state_q == WRESP ? bus.m_axi_bresp : bus.m_axi_rresp;
      rsp_valid_d = grant_q ? 2'b10 : 2'b01;
      state_d = IDLE;
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      grant_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      rdata_q <= '0;
      resp_q <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      grant_q <= grant_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_rr_master.sv
// tb_axi4_lite_rr_master: scoreboard bench with a configurable-wait AXI4-Lite slave model.
module tb_axi4_lite_rr_master;
  typedef struct packed {logic id; logic [31:0] rdata; logic [1:0] resp;} exp_t;
  logic aclk, aresetn;
  int tests = 0, fails = 0;
  exp_t sb[$];
  logic [31:0] model_mem [16];
  axi4_lite_rr_master_if #(.ADDRESS_SIZE(4), .DATA_SIZE(32)) bus();
  axi4_lite_rr_master #(.ADDRESS_SIZE(4), .DATA_SIZE(32)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic [120:0] dut_outs;
  assign dut_outs = {bus.r0_ready, bus.r1_ready, bus.r0_rsp_valid, bus.r1_rsp_valid, bus.r0_rsp_rdata, bus.r1_rsp_rdata,
                     bus.r0_rsp_resp, bus.r1_rsp_resp, bus.m_axi_awaddr, bus.m_axi_awvalid, bus.m_axi_wdata, bus.m_axi_wstrb,
                     bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_araddr, bus.m_axi_arvalid, bus.m_axi_rready};
  // slave model: ready after N wait cycles, memory committed on the B handshake
  logic [31:0] smem [16];
  logic aw_got, w_got, r_got;
  logic [3:0] aw_a, ar_a, w_s;
  logic [31:0] w_d;
  int aw_c, w_c, ar_c, b_c;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0;
  logic [1:0] rresp_force = 2'b00;
  assign bus.m_axi_awready = bus.m_axi_awvalid && aw_c >= aw_wait;
  assign bus.m_axi_wready = bus.m_axi_wvalid && w_c >= w_wait;
  assign bus.m_axi_arready = bus.m_axi_arvalid && ar_c >= ar_wait;
  assign bus.m_axi_bvalid = aw_got && w_got && b_c >= b_wait;
  assign bus.m_axi_bresp = 2'b00;
  assign bus.m_axi_rvalid = r_got;
  assign bus.m_axi_rdata = smem[ar_a];
  assign bus.m_axi_rresp = rresp_force;
  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_got <= 1'b0;
      aw_c <= 0; w_c <= 0; ar_c <= 0; b_c <= 0;
      aw_a <= '0; ar_a <= '0; w_s <= '0; w_d <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= 32'hA5A5_0000 | 32'(i * 257);
    end else begin
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin aw_got <= 1'b1; aw_a <= bus.m_axi_awaddr; aw_c <= 0; end
      else if (bus.m_axi_awvalid) aw_c <= aw_c + 1;
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin w_got <= 1'b1; w_d <= bus.m_axi_wdata; w_s <= bus.m_axi_wstrb; w_c <= 0; end
      else if (bus.m_axi_wvalid) w_c <= w_c + 1;
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_c <= 0;
        for (int b = 0; b < 4; b++) if (w_s[b]) smem[aw_a][8*b +: 8] <= w_d[8*b +: 8];
      end else if (aw_got && w_got) b_c <= b_c + 1;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin r_got <= 1'b1; ar_a <= bus.m_axi_araddr; ar_c <= 0; end
      else if (bus.m_axi_arvalid) ar_c <= ar_c + 1;
      if (bus.m_axi_rvalid && bus.m_axi_rready) r_got <= 1'b0;
    end
  end
  // response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge aclk) begin
    if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
      tests++;
      if (bus.r0_rsp_valid && bus.r1_rsp_valid) begin
        fails++; $display("FAIL rsp_both: r0 and r1 pulsed together, required one");
      end else if (sb.size() == 0) begin
        fails++; $display("FAIL rsp_unexpected: pulse on r%0d, required none", bus.r1_rsp_valid);
      end else begin
        exp_t e, o;
        e = sb.pop_front();
        o = bus.r1_rsp_valid ? {1'b1, bus.r1_rsp_rdata, bus.r1_rsp_resp} : {1'b0, bus.r0_rsp_rdata, bus.r0_rsp_resp};
        if (o !== e) begin
          fails++; $display("FAIL rsp_data: got id=%0d rdata=%h resp=%b, required id=%0d rdata=%h resp=%b",
                            o.id, o.rdata, o.resp, e.id, e.rdata, e.resp);
        end
      end
    end
  end
  task automatic model_init;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'hA5A5_0000 | 32'(i * 257);
  endtask
  task automatic set_req(input bit n, input bit v, input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    if (n) begin bus.r1_valid = v; bus.r1_write = wr; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_wstrb = s; end
    else begin bus.r0_valid = v; bus.r0_write = wr; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_wstrb = s; end
  endtask
  task automatic expect_rsp(input bit n, input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    sb.push_back({n, wr ? 32'h0 : model_mem[a], er});
    if (wr) for (int b = 0; b < 4; b++) if (s[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic wait_drain(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 50) begin @(posedge aclk); @(negedge aclk); #1; t++; end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL %s_drain: %0d responses outstanding, required 0", nm, sb.size()); sb.delete(); end
  endtask
  task automatic xact(input bit n, input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    int t = 0;
    set_req(n, 1'b1, wr, a, d, s);
    #1;
    while (!(n ? bus.r1_ready : bus.r0_ready) && t < 50) begin @(negedge aclk); #1; t++; end
    tests++;
    if (t >= 50) begin fails++; $display("FAIL xact_grant: r%0d ready never seen, required within 50 cycles", n); end
    else expect_rsp(n, wr, a, d, s, er);
    @(negedge aclk);
    set_req(n, 1'b0, 1'b0, '0, '0, '0);
    wait_drain("xact");
  endtask
  task automatic do_reset;
    aresetn = 1'b0;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    repeat (2) @(negedge aclk);
    model_init();
    aresetn = 1'b1;
    #1;
  endtask
  task automatic test_reset;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    tests++;
    if (dut_outs !== '0) begin fails++; $display("FAIL reset_outs: got %h, required 0", dut_outs); end
    set_req(0, 1'b1, 1'b0, 4'h1, '0, '0);
    #1;
    tests++;
    if (bus.r0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: r0_ready=%b during reset, required 0", bus.r0_ready); end
    @(negedge aclk);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    model_init();
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    tests++;
    if (dut_outs !== '0) begin fails++; $display("FAIL reset_idle: got %h, required 0", dut_outs); end
  endtask
  task automatic test_single_write;
    set_req(0, 1'b1, 1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
    #1;
    tests++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin fails++; $display("FAIL sw_c0_ready: got %b, required 10", {bus.r0_ready, bus.r1_ready}); end
    expect_rsp(0, 1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge aclk);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    tests++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb} !== {3'b110, 4'h4, 32'hDEADBEEF, 4'hF}) begin
      fails++; $display("FAIL sw_c1_aw_w: got aw=%b w=%b ar=%b addr=%h data=%h strb=%h, required 1 1 0 4 deadbeef f",
                        bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb);
    end
    @(negedge aclk);
    #1;
    tests++;
    if ({bus.m_axi_bready, bus.m_axi_awvalid, bus.m_axi_wvalid} !== 3'b100) begin
      fails++; $display("FAIL sw_c2_bready: got bready/aw/w=%b, required 100", {bus.m_axi_bready, bus.m_axi_awvalid, bus.m_axi_wvalid});
    end
    @(negedge aclk);
    #1;
    tests++;
    if ({bus.r0_rsp_valid, bus.r1_rsp_valid, bus.r0_rsp_resp} !== 4'b1000) begin
      fails++; $display("FAIL sw_c3_rsp: got r0v/r1v/resp=%b, required 1000", {bus.r0_rsp_valid, bus.r1_rsp_valid, bus.r0_rsp_resp});
    end
    @(negedge aclk);
    #1;
    tests++;
    if ({bus.r0_rsp_valid, bus.r1_rsp_valid} !== 2'b00) begin fails++; $display("FAIL sw_c4_pulse: got %b, required 00", {bus.r0_rsp_valid, bus.r1_rsp_valid}); end
    wait_drain("single_write");
  endtask
  task automatic test_round_robin;
    logic [3:0] a0 = 4'h1, a1 = 4'h9;
    int nexp = 0, got = 0, t = 0;
    do_reset();
    set_req(0, 1'b1, 1'b0, a0, '0, '0);
    set_req(1, 1'b1, 1'b0, a1, '0, '0);
    #1;
    while (got < 4 && t < 60) begin
      if (bus.r0_ready || bus.r1_ready) begin
        bit w = bus.r1_ready;
        tests++;
        if ((bus.r0_ready && bus.r1_ready) || int'(w) != nexp) begin
          fails++; $display("FAIL rr_order: grant %0d got r0=%b r1=%b, required r%0d", got, bus.r0_ready, bus.r1_ready, nexp);
        end
        expect_rsp(w, 1'b0, w ? a1 : a0, '0, '0, 2'b00);
        nexp ^= 1;
        got++;
        @(posedge aclk);
        #1;
        if (w) begin a1++; set_req(1, 1'b1, 1'b0, a1, '0, '0); end
        else begin a0++; set_req(0, 1'b1, 1'b0, a0, '0, '0); end
      end
      @(negedge aclk);
      #1;
      t++;
    end
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    tests++;
    if (got != 4) begin fails++; $display("FAIL rr_count: got %0d grants, required 4", got); end
    wait_drain("round_robin");
  endtask
  task automatic test_write_wait;
    int aw_n = 0, w_n = 0, pulses = 0;
    aw_wait = 3;
    set_req(0, 1'b1, 1'b1, 4'h8, 32'h0BAD_F00D, 4'hF);
    #1;
    tests++;
    if (bus.r0_ready !== 1'b1) begin fails++; $display("FAIL ww_ready: r0_ready=%b, required 1", bus.r0_ready); end
    expect_rsp(0, 1'b1, 4'h8, 32'h0BAD_F00D, 4'hF, 2'b00);
    for (int c = 1; c <= 7; c++) begin
      @(negedge aclk);
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      aw_n += int'(bus.m_axi_awvalid);
      w_n += int'(bus.m_axi_wvalid);
      pulses += int'(bus.r0_rsp_valid) + int'(bus.r1_rsp_valid);
      tests++;
      if (bus.m_axi_bready !== (c == 5)) begin fails++; $display("FAIL ww_bready: cycle %0d bready=%b, required %b", c, bus.m_axi_bready, c == 5); end
    end
    aw_wait = 0;
    tests++;
    if ({aw_n, w_n, pulses} !== {32'd4, 32'd1, 32'd1}) begin
      fails++; $display("FAIL ww_counts: awvalid=%0d wvalid=%0d pulses=%0d cycles, required 4 1 1", aw_n, w_n, pulses);
    end
    wait_drain("write_wait");
  endtask
  task automatic test_read_error;
    xact(1, 1'b1, 4'h3, 32'h0000_1234, 4'hF, 2'b00);
    rresp_force = 2'b10;
    xact(1, 1'b0, 4'h3, '0, '0, 2'b10);
    rresp_force = 2'b00;
    @(negedge aclk);
    #1;
    tests++;
    if ({bus.r1_rsp_valid, bus.r1_rsp_resp, bus.r1_rsp_rdata} !== {1'b0, 2'b10, 32'h0000_1234}) begin
      fails++; $display("FAIL re_hold: got v=%b resp=%b rdata=%h, required 0 10 00001234", bus.r1_rsp_valid, bus.r1_rsp_resp, bus.r1_rsp_rdata);
    end
    xact(0, 1'b0, 4'h7, '0, '0, 2'b00);
  endtask
  task automatic test_strobe;
    xact(0, 1'b1, 4'h2, 32'hAABB_CCDD, 4'h5, 2'b00);
    xact(1, 1'b0, 4'h2, '0, '0, 2'b00);
  endtask
  task automatic test_reset_in_wresp;
    int pulses = 0;
    b_wait = 4;
    set_req(0, 1'b1, 1'b1, 4'h5, 32'h5555_5555, 4'hF);
    @(negedge aclk);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge aclk);
    #1;
    tests++;
    if (bus.m_axi_bready !== 1'b1) begin fails++; $display("FAIL rw_wresp: bready=%b, required 1", bus.m_axi_bready); end
    aresetn = 1'b0;
    @(negedge aclk);
    #1;
    tests++;
    if (dut_outs !== '0) begin fails++; $display("FAIL rw_outs: got %h, required 0", dut_outs); end
    aresetn = 1'b1;
    b_wait = 0;
    model_init();
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      #1;
      pulses += int'(bus.r0_rsp_valid) + int'(bus.r1_rsp_valid);
    end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL rw_no_pulse: got %0d pulses, required 0", pulses); end
    xact(1, 1'b1, 4'h6, 32'h1357_9BDF, 4'hF, 2'b00);
    xact(1, 1'b0, 4'h6, '0, '0, 2'b00);
  endtask
  task automatic test_r1_only;
    logic [3:0] a = 4'hC;
    int got = 0, t = 0, last_t = 0, r0_seen = 0;
    set_req(1, 1'b1, 1'b0, a, '0, '0);
    #1;
    while (got < 4 && t < 60) begin
      r0_seen += int'(bus.r0_ready);
      if (bus.r1_ready) begin
        if (got > 0) begin
          tests++;
          if (t - last_t != 3) begin fails++; $display("FAIL r1_gap: grant gap %0d cycles, required 3", t - last_t); end
        end
        expect_rsp(1, 1'b0, a, '0, '0, 2'b00);
        last_t = t;
        got++;
        @(posedge aclk);
        #1;
        a++;
        set_req(1, 1'b1, 1'b0, a, '0, '0);
      end
      @(negedge aclk);
      #1;
      t++;
    end
    set_req(1, 0, 0, '0, '0, '0);
    tests++;
    if (got != 4 || r0_seen != 0) begin fails++; $display("FAIL r1_only: grants=%0d r0_ready=%0d, required 4 0", got, r0_seen); end
    wait_drain("r1_only");
  endtask
  initial begin
    aresetn = 1'b0;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    model_init();
    test_reset();
    test_single_write();
    test_round_robin();
    test_write_wait();
    test_read_error();
    test_strobe();
    test_reset_in_wresp();
    test_r1_only();
    repeat (3) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
